// File: rtl/instr_fetch_sequencer_pkg.sv
// Shared types and default sizing for the variable-length instruction fetch sequencer.
package instr_fetch_sequencer_pkg;

  localparam int              DATA_WIDTH_DEF        = 8;
  localparam int              ADDR_WIDTH_DEF        = 16;
  localparam int              MAX_OPERAND_BYTES_DEF = 2;
  localparam int              MAX_MICROSTEPS_DEF    = 8;
  localparam logic [15:0]     RESET_VECTOR_DEF      = 16'hF000;

  localparam int MICROSTEP_W = $clog2(MAX_MICROSTEPS_DEF);
  typedef logic [MICROSTEP_W-1:0] microstep_t;

  typedef enum logic [3:0] {
    S_RESET          = 4'd0,
    S_INIT           = 4'd1,
    S_LATCH_ADDR     = 4'd2,
    S_READ_BYTE      = 4'd3,
    S_LATCH_BYTE     = 4'd4,
    S_CHK_MORE_BYTES = 4'd5,
    S_EXECUTE        = 4'd6,
    S_HALT           = 4'd7
  } fsm_state_t;

endpackage

// File: rtl/instr_fetch_sequencer_if.sv
// Bundle between the sequencer, the byte-wide fetch RAM and the microcode/decoder side.
interface instr_fetch_sequencer_if
  import instr_fetch_sequencer_pkg::*;
#(
  parameter int DATA_WIDTH        = DATA_WIDTH_DEF,
  parameter int ADDR_WIDTH        = ADDR_WIDTH_DEF,
  parameter int MAX_OPERAND_BYTES = MAX_OPERAND_BYTES_DEF,
  parameter int MAX_MICROSTEPS    = MAX_MICROSTEPS_DEF
) ();

  localparam int LEN_W = $clog2(MAX_OPERAND_BYTES + 1);
  localparam int MS_W  = $clog2(MAX_MICROSTEPS);

  logic [ADDR_WIDTH-1:0]                   mem_addr;
  logic                                    mem_rd;
  logic [DATA_WIDTH-1:0]                   mem_rdata;
  logic [DATA_WIDTH-1:0]                   opcode;
  logic [MAX_OPERAND_BYTES*DATA_WIDTH-1:0] operand;
  logic [LEN_W-1:0]                        operand_len;
  logic [MS_W-1:0]                         microstep;
  logic                                    exec_active;
  logic                                    last_step;
  logic                                    halt;
  logic                                    pc_load;
  logic [ADDR_WIDTH-1:0]                   pc_load_value;
  logic [ADDR_WIDTH-1:0]                   pc;
  logic                                    halted;
  logic                                    fault;

  modport master (
    output mem_addr, mem_rd, opcode, operand, microstep, exec_active, pc, halted, fault,
    input  mem_rdata, operand_len, last_step, halt, pc_load, pc_load_value
  );

  modport slave (
    input  mem_addr, mem_rd, opcode, operand, microstep, exec_active, pc, halted, fault,
    output mem_rdata, operand_len, last_step, halt, pc_load, pc_load_value
  );

endinterface

// File: rtl/instr_fetch_sequencer_program_counter.sv
// Program counter register: load has priority over increment, increment wraps at 2^ADDR_WIDTH.
module program_counter #(
  parameter int ADDR_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load_en,
  input  logic [ADDR_WIDTH-1:0] load_value,
  input  logic                  inc_en,
  output logic [ADDR_WIDTH-1:0] pc
);

  logic [ADDR_WIDTH-1:0] pc_r;

  // pc register update
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_r <= '0;
    end else if (load_en) begin
      pc_r <= load_value;
    end else if (inc_en) begin
      pc_r <= pc_r + ADDR_WIDTH'(1);
    end else begin
      pc_r <= pc_r;
    end
  end

  assign pc = pc_r;

endmodule

// File: rtl/instr_fetch_sequencer.sv
// Variable-length fetch/execute sequencer: fetches opcode plus operand bytes from sync RAM,
// then runs microsteps until microcode reports last_step or halt.
module instr_fetch_sequencer
  import instr_fetch_sequencer_pkg::*;
#(
  parameter int                    DATA_WIDTH        = DATA_WIDTH_DEF,
  parameter int                    ADDR_WIDTH        = ADDR_WIDTH_DEF,
  parameter int                    MAX_OPERAND_BYTES = MAX_OPERAND_BYTES_DEF,
  parameter int                    MAX_MICROSTEPS    = MAX_MICROSTEPS_DEF,
  parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR      = ADDR_WIDTH'(RESET_VECTOR_DEF)
) (
  input logic                      clk,
  input logic                      reset,
  instr_fetch_sequencer_if.master  bus
);

  localparam int LEN_W = $clog2(MAX_OPERAND_BYTES + 1);
  // byte_idx counts the opcode too, so it must reach MAX_OPERAND_BYTES+1
  localparam int IDX_W = $clog2(MAX_OPERAND_BYTES + 2);
  localparam int MS_W  = $clog2(MAX_MICROSTEPS);
  localparam int OPW   = MAX_OPERAND_BYTES * DATA_WIDTH;

  fsm_state_t            state_r;
  fsm_state_t            state_nxt_s;
  logic [IDX_W-1:0]      byte_idx_r;
  logic [MS_W-1:0]       microstep_r;
  logic [DATA_WIDTH-1:0] opcode_r;
  logic [OPW-1:0]        operand_r;
  logic                  mem_rd_r;
  logic                  exec_active_r;
  logic                  halted_r;
  logic                  fault_r;

  logic [ADDR_WIDTH-1:0] pc_s;
  logic [ADDR_WIDTH-1:0] pc_load_value_s;
  logic                  pc_load_s;
  logic                  pc_inc_s;
  logic                  fault_set_s;
  logic                  len_bad_s;
  logic                  more_bytes_s;
  logic                  ms_last_s;

  assign len_bad_s    = (bus.operand_len > LEN_W'(MAX_OPERAND_BYTES));
  assign more_bytes_s = (byte_idx_r <= IDX_W'(bus.operand_len));
  assign ms_last_s    = (microstep_r == MS_W'(MAX_MICROSTEPS - 1));

  program_counter #(.ADDR_WIDTH(ADDR_WIDTH)) u_pc (
    .clk        (clk),
    .reset      (reset),
    .load_en    (pc_load_s),
    .load_value (pc_load_value_s),
    .inc_en     (pc_inc_s),
    .pc         (pc_s)
  );

  // state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= S_RESET;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // next-state decode and pc/fault strobes
  always_comb begin
    state_nxt_s     = state_r;
    pc_load_s       = 1'b0;
    pc_load_value_s = bus.pc_load_value;
    pc_inc_s        = 1'b0;
    fault_set_s     = 1'b0;
    case (state_r)
      S_RESET: begin
        state_nxt_s = S_INIT;
      end
      S_INIT: begin
        pc_load_s       = 1'b1;
        pc_load_value_s = RESET_VECTOR;
        state_nxt_s     = S_LATCH_ADDR;
      end
      S_LATCH_ADDR: begin
        state_nxt_s = S_READ_BYTE;
      end
      S_READ_BYTE: begin
        state_nxt_s = S_LATCH_BYTE;
      end
      S_LATCH_BYTE: begin
        pc_inc_s    = 1'b1;
        state_nxt_s = S_CHK_MORE_BYTES;
      end
      S_CHK_MORE_BYTES: begin
        if (len_bad_s) begin
          fault_set_s = 1'b1;
          state_nxt_s = S_HALT;
        end else if (more_bytes_s) begin
          state_nxt_s = S_LATCH_ADDR;
        end else begin
          state_nxt_s = S_EXECUTE;
        end
      end
      S_EXECUTE: begin
        // a jump taken together with last_step steers the very next fetch
        pc_load_s = bus.pc_load;
        if (bus.halt) begin
          state_nxt_s = S_HALT;
        end else if (bus.last_step) begin
          state_nxt_s = S_LATCH_ADDR;
        end else if (ms_last_s) begin
          fault_set_s = 1'b1;
          state_nxt_s = S_HALT;
        end else begin
          state_nxt_s = S_EXECUTE;
        end
      end
      S_HALT: begin
        state_nxt_s = S_HALT;
      end
      default: begin
        state_nxt_s = S_RESET;
      end
    endcase
  end

  // byte index, opcode/operand latches and microstep counter
  always_ff @(posedge clk) begin
    if (reset) begin
      byte_idx_r  <= '0;
      opcode_r    <= '0;
      operand_r   <= '0;
      microstep_r <= '0;
    end else begin
      case (state_r)
        S_INIT: begin
          byte_idx_r <= '0;
        end
        S_LATCH_BYTE: begin
          if (byte_idx_r == IDX_W'(0)) begin
            opcode_r  <= bus.mem_rdata;
            operand_r <= '0;
          end else begin
            for (int b = 0; b < MAX_OPERAND_BYTES; b++) begin
              if (byte_idx_r == IDX_W'(b + 1)) begin
                operand_r[b*DATA_WIDTH +: DATA_WIDTH] <= bus.mem_rdata;
              end
            end
          end
          byte_idx_r <= byte_idx_r + IDX_W'(1);
        end
        S_CHK_MORE_BYTES: begin
          microstep_r <= '0;
        end
        S_EXECUTE: begin
          // microstep reads 0 whenever the sequencer is not executing
          if (state_nxt_s == S_EXECUTE) begin
            microstep_r <= microstep_r + MS_W'(1);
          end else begin
            microstep_r <= '0;
            byte_idx_r  <= '0;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // registered status outputs, decoded from the upcoming state
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_rd_r      <= 1'b0;
      exec_active_r <= 1'b0;
      halted_r      <= 1'b0;
      fault_r       <= 1'b0;
    end else begin
      mem_rd_r      <= (state_nxt_s == S_READ_BYTE);
      exec_active_r <= (state_nxt_s == S_EXECUTE);
      halted_r      <= (state_nxt_s == S_HALT);
      fault_r       <= fault_r | fault_set_s;
    end
  end

  assign bus.mem_addr    = pc_s;
  assign bus.mem_rd      = mem_rd_r;
  assign bus.opcode      = opcode_r;
  assign bus.operand     = operand_r;
  assign bus.microstep   = microstep_r;
  assign bus.exec_active = exec_active_r;
  assign bus.pc          = pc_s;
  assign bus.halted      = halted_r;
  assign bus.fault       = fault_r;

endmodule
